inv_linear: RTL and testbench



---
 rtl/inv_linear_if.sv | 28 ++
 rtl/inv_linear.sv | 138 +++++++++++++
 tb/tb_inv_linear.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_linear_if.sv
// Ready/valid block interface for inv_linear: an upstream load channel and a downstream
// result channel. The _i/_o suffixes are from the transform block's point of view.
interface inv_linear_if;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] data_o;

  modport slave (
    input  valid_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o
  );
endinterface

// File: rtl/inv_linear.sv
// Iterative Kuznyechik inverse linear transform L^-1 = (R^-1)^16, UNROLL steps per clock.
// Define INV_LINEAR_FORWARD_EN to add mode_i and the forward L = R^16 path.
module inv_linear #(
  parameter int unsigned UNROLL = 1
) (
  input  logic    clk,
  input  logic    rst,
`ifdef INV_LINEAR_FORWARD_EN
  input  logic    mode_i,
`endif
  inv_linear_if.slave bus
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16))
  begin : g_bad_unroll
    $error("inv_linear: UNROLL must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

  // Multiply by a constant over GF(2^8) mod x^8+x^7+x^6+x+1 as an xtime chain.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // Coefficient of byte b_i in l(b15..b0).
  function automatic logic [7:0] coef(input int i);
    case (i)
      0, 7, 9:  coef = 8'd1;
      1, 15:    coef = 8'd148;
      2, 14:    coef = 8'd32;
      3, 13:    coef = 8'd133;
      4, 12:    coef = 8'd16;
      5, 11:    coef = 8'd194;
      6, 10:    coef = 8'd192;
      default:  coef = 8'd251;
    endcase
  endfunction

  function automatic logic [7:0] l_fn(input logic [127:0] b);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 16; i++) acc = acc ^ gf_mul(b[8*i +: 8], coef(i));
    return acc;
  endfunction

  // Old a15 is only the last argument of l; the new byte enters at the bottom.
  function automatic logic [127:0] inv_step(input logic [127:0] s);
    return {s[119:0], l_fn({s[119:0], s[127:120]})};
  endfunction

`ifdef INV_LINEAR_FORWARD_EN
  function automatic logic [127:0] fwd_step(input logic [127:0] s);
    return {l_fn(s), s[127:8]};
  endfunction
`endif

  fsm_e         fsm_q, fsm_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic [127:0] step;
`ifdef INV_LINEAR_FORWARD_EN
  logic         mode_q, mode_d;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    step    = state_q;
`ifdef INV_LINEAR_FORWARD_EN
    mode_d  = mode_q;
    for (int unsigned k = 0; k < UNROLL; k++) step = mode_q ? fwd_step(step) : inv_step(step);
`else
    for (int unsigned k = 0; k < UNROLL; k++) step = inv_step(step);
`endif
    case (fsm_q)
      StIdle: begin
        if (bus.valid_i) begin
          state_d = bus.data_i;
          cnt_d   = 5'd0;
`ifdef INV_LINEAR_FORWARD_EN
          mode_d  = mode_i;
`endif
          fsm_d   = StBusy;
        end
      end
      StBusy: begin
        state_d = step;
        cnt_d   = cnt_q + 5'(UNROLL);
        if (cnt_d == 5'd16) fsm_d = StDone;
      end
      StDone: begin
        if (bus.ready_i) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
    ready_d = (fsm_d == StIdle);
    valid_d = (fsm_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      cnt_q   <= 5'd0;
      state_q <= 128'h0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef INV_LINEAR_FORWARD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef INV_LINEAR_FORWARD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = state_q;

endmodule

// File: tb/tb_inv_linear.sv
// Self-checking bench for inv_linear: three instances (UNROLL 1, 4, 16) checked against
// known-answer vectors and a byte-array reference model of the Kuznyechik L / L^-1.
module tb_inv_linear;

  localparam int NDUT = 3;

  logic clk;
  logic rst;
  logic         valid_a [NDUT];
  logic         ready_a [NDUT];
  logic [127:0] data_a  [NDUT];
  logic         vo_a    [NDUT];
  logic         ro_a    [NDUT];
  logic [127:0] do_a    [NDUT];
`ifdef INV_LINEAR_FORWARD_EN
  logic         mode_a  [NDUT];
`endif

  int checks   = 0;
  int failures = 0;
  time t_load [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    inv_linear_if bus ();
    inv_linear #(.UNROLL(U)) u_dut (
      .clk    (clk),
      .rst    (rst),
`ifdef INV_LINEAR_FORWARD_EN
      .mode_i (mode_a[g]),
`endif
      .bus    (bus)
    );
    assign bus.valid_i = valid_a[g];
    assign bus.data_i  = data_a[g];
    assign bus.ready_i = ready_a[g];
    assign vo_a[g]     = bus.valid_o;
    assign ro_a[g]     = bus.ready_o;
    assign do_a[g]     = bus.data_o;
  end

  // ---------------- reference model ----------------
  // l coefficients indexed by byte position b0..b15.
  localparam logic [7:0] LC [16] = '{8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
                                     8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};

  // Carry-less product followed by polynomial long division by 0x1C3.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h1C3) << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] l_inv_model(input logic [127:0] x);
    logic [7:0] a [16];
    logic [7:0] t;
    logic [7:0] s;
    for (int i = 0; i < 16; i++) a[i] = x[8*i +: 8];
    repeat (16) begin
      t = a[15];
      for (int i = 15; i > 0; i--) a[i] = a[i-1];
      s = gmul(t, LC[0]);
      for (int i = 1; i < 16; i++) s = s ^ gmul(a[i], LC[i]);
      a[0] = s;
    end
    for (int i = 0; i < 16; i++) x[8*i +: 8] = a[i];
    return x;
  endfunction

`ifdef INV_LINEAR_FORWARD_EN
  function automatic logic [127:0] l_fwd_model(input logic [127:0] x);
    logic [7:0] a [16];
    logic [7:0] s;
    for (int i = 0; i < 16; i++) a[i] = x[8*i +: 8];
    repeat (16) begin
      s = 8'h00;
      for (int i = 0; i < 16; i++) s = s ^ gmul(a[i], LC[i]);
      for (int i = 0; i < 15; i++) a[i] = a[i+1];
      a[15] = s;
    end
    for (int i = 0; i < 16; i++) x[8*i +: 8] = a[i];
    return x;
  endfunction
`endif

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a block, wait (bounded) for ready_o, return just after the load edge.
  task automatic load(input int d, input logic [127:0] x);
    int guard;
    guard = 0;
    @(negedge clk);
    valid_a[d] = 1'b1;
    data_a[d]  = x;
    while (!ro_a[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("load_timeout", 128'(guard), 128'd0);
    @(posedge clk);
    t_load[d] = $time;
    #1;
    valid_a[d] = 1'b0;
  endtask

  // Count edges from the load edge until valid_o, checking ready_o stays low meanwhile.
  task automatic wait_result(input int d, input int exp_lat, output logic [127:0] res);
    int lat;
    logic rdy_seen;
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (ro_a[d]) rdy_seen = 1'b1;
    end while (!vo_a[d] && lat < 40);
    chk($sformatf("latency_u%0d", d), 128'(lat), 128'(exp_lat));
    chk($sformatf("ready_low_u%0d", d), 128'(rdy_seen), 128'd0);
    res = do_a[d];
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 1;
  endfunction

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] VA = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] VB = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] VC = 128'h79d26221b87b584cd42fbc4ffea5de9a;
  localparam logic [127:0] VD = 128'h0e93691a0cfc60408b7b68f66b513c13;
  localparam logic [127:0] VE = 128'he6a8094fee0aa204fd97bcb0b44b8580;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    logic [127:0] res;
    logic [127:0] x;
    logic flag;
    time prev;

    tbl[0] = '{din: VB, exp: VA};
    tbl[1] = '{din: VC, exp: VB};
    tbl[2] = '{din: VD, exp: VC};
    tbl[3] = '{din: VE, exp: VD};
    tbl[4] = '{din: 128'h0, exp: 128'h0};

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      valid_a[d] = 1'b0;
      ready_a[d] = 1'b1;
      data_a[d]  = '0;
`ifdef INV_LINEAR_FORWARD_EN
      mode_a[d]  = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_ready_u%0d", d), 128'(ro_a[d]), 128'd1);
      chk($sformatf("rst_valid_u%0d", d), 128'(vo_a[d]), 128'd0);
      chk($sformatf("rst_data_u%0d", d), do_a[d], 128'h0);
    end
    rst = 1'b0;

    // Single R^-1 step seen through the state register.
    load(0, 128'h94000000000000000000000000000001);
    @(posedge clk);
    #1;
    chk("single_step", g_dut[0].u_dut.state_q, 128'h00000000000000000000000000000100);
    wait_result(0, 15, res);
    chk("single_step_full", res, l_inv_model(128'h94000000000000000000000000000001));

    // Known-answer vectors on every unroll factor.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 5; i++) begin
        load(d, tbl[i].din);
        wait_result(d, lat_of(d), res);
        chk($sformatf("kat%0d_u%0d", i, d), res, tbl[i].exp);
      end
    end

    // Backpressure: hold the result for 10 cycles with an ignored valid_i pulse.
    ready_a[0] = 1'b0;
    load(0, VB);
    wait_result(0, 16, res);
    chk("bp_first", res, VA);
    flag = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        valid_a[0] = 1'b1;
        data_a[0]  = VE;
      end
      if (c == 5) valid_a[0] = 1'b0;
      @(posedge clk);
      #1;
      if (!vo_a[0] || do_a[0] !== VA || ro_a[0]) flag = 1'b0;
    end
    chk("bp_stable", 128'(flag), 128'd1);
    ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 128'(ro_a[0]), 128'd1);
    chk("bp_idle_valid", 128'(vo_a[0]), 128'd0);

    // Reset at cycle 7 of BUSY, then rst together with valid_i.
    load(0, VB);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 128'(ro_a[0]), 128'd1);
    chk("mid_rst_valid", 128'(vo_a[0]), 128'd0);
    chk("mid_rst_data", do_a[0], 128'h0);
    valid_a[0] = 1'b1;
    data_a[0]  = VC;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_a[0] = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (vo_a[0] || !ro_a[0] || do_a[0] !== 128'h0) flag = 1'b1;
    end
    chk("rst_valid_not_loaded", 128'(flag), 128'd0);
    load(0, VB);
    wait_result(0, 16, res);
    chk("post_rst_result", res, VA);

    // Random blocks back-to-back against the model, with throughput check.
    for (int d = 0; d < NDUT; d++) begin
      prev = 0;
      for (int n = 0; n < 100; n++) begin
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        load(d, x);
        if (n > 0) chk($sformatf("period_u%0d", d), 128'(t_load[d] - prev),
                       128'((lat_of(d) + 2) * 10));
        prev = t_load[d];
        wait_result(d, lat_of(d), res);
        chk($sformatf("rand_u%0d_n%0d", d, n), res, l_inv_model(x));
      end
    end

`ifdef INV_LINEAR_FORWARD_EN
    for (int d = 0; d < NDUT; d++) begin
      mode_a[d] = 1'b1;
      load(d, VA);
      wait_result(d, lat_of(d), res);
      chk($sformatf("fwd_kat_u%0d", d), res, VB);
      mode_a[d] = 1'b0;
      load(d, res);
      wait_result(d, lat_of(d), res);
      chk($sformatf("fwd_roundtrip_u%0d", d), res, VA);
      for (int n = 0; n < 20; n++) begin
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode_a[d] = n[0];
        load(d, x);
        mode_a[d] = ~n[0];
        wait_result(d, lat_of(d), res);
        chk($sformatf("fwd_rand_u%0d_n%0d", d, n), res,
            n[0] ? l_fwd_model(x) : l_inv_model(x));
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
